// File: rtl/fft_frame_sequencer_pkg.sv
// Shared types and default sizing for the FFT frame sequencer and its ping-pong sample buffer.
package fft_frame_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        KICK = 2'd1,
        WAIT = 2'd2
    } seq_state_t;

    typedef enum logic [1:0] {
        FREE    = 2'd0,
        FILLING = 2'd1,
        READY   = 2'd2,
        PROC    = 2'd3
    } bank_state_t;

    localparam int FFT_N       = 256;
    localparam int FFT_TIMEOUT = 4096;
    localparam int CNT_W       = $clog2(FFT_N);
    localparam int TMR_W       = $clog2(FFT_TIMEOUT);

    function automatic logic bank_writable(input bank_state_t s);
        return (s == FREE) || (s == FILLING);
    endfunction

endpackage

// File: rtl/fft_frame_sequencer_pingpong_buf.sv
// Two N x SAMPLE_W sample banks: single write port, whole-frame read of the bank picked by rd_sel.
module sample_pingpong_buf
    import fft_frame_sequencer_pkg::*;
#(
    parameter int N        = FFT_N,
    parameter int SAMPLE_W = 12,
    parameter int ADDR_W   = CNT_W
) (
    input  logic                         clk,
    input  logic                         we,
    input  logic                         wr_sel,
    input  logic [ADDR_W-1:0]            wr_cnt,
    input  logic [SAMPLE_W-1:0]          wr_data,
    input  logic                         rd_sel,
    output logic [0:N-1][SAMPLE_W-1:0]   rd_frame
);

    logic [SAMPLE_W-1:0] bank0_r [N];
    logic [SAMPLE_W-1:0] bank1_r [N];

    // Sample storage; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (we) begin
            if (wr_sel) begin
                bank1_r[wr_cnt] <= wr_data;
            end else begin
                bank0_r[wr_cnt] <= wr_data;
            end
        end
    end

    // Full-frame read mux.
    always_comb begin
        for (int k = 0; k < N; k++) begin
            rd_frame[k] = rd_sel ? bank1_r[k] : bank0_r[k];
        end
    end

endmodule

// File: rtl/fft_frame_sequencer.sv
// Ping-pong frame capture in front of fft_256: fills one bank while the other is transformed,
// kicks the FFT, waits for its done edge (or a timeout) and reports frame completion.
module fft_frame_sequencer
    import fft_frame_sequencer_pkg::*;
#(
    parameter int WIDTH    = 18,
    parameter int N        = FFT_N,
    parameter int SAMPLE_W = 12,
    parameter int TIMEOUT  = FFT_TIMEOUT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sample_valid,
    input  logic [SAMPLE_W-1:0]        sample_in,
    output logic                       fft_start,
    input  logic                       fft_done,
    output logic [0:N-1][WIDTH-1:0]    fft_samples,
    output logic                       frame_ready,
    output logic                       busy,
    output logic                       overrun,
    output logic                       fft_timeout
);

    localparam int CW = (N == FFT_N) ? CNT_W : $clog2(N);
    localparam int TW = (TIMEOUT == FFT_TIMEOUT) ? TMR_W : $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
    localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT - 1);

    seq_state_t               state_r;
    bank_state_t              bank_st_r [2];
    logic                     rd_sel_r;
    logic                     wr_sel_r;
    logic                     done_q_r;
    logic [CW-1:0]            wr_cnt_r;
    logic [TW-1:0]            timer_r;

    logic                     done_edge_s;
    logic                     release_s;
    logic                     other_sel_s;
    logic                     can_wr_s;
    logic                     tgt_s;
    logic                     we_s;
    logic                     last_s;
    logic                     other_free_s;
    logic                     claim_sel_s;
    logic [0:N-1][SAMPLE_W-1:0] rd_frame_s;

    sample_pingpong_buf #(
        .N        (N),
        .SAMPLE_W (SAMPLE_W),
        .ADDR_W   (CW)
    ) u_buf (
        .clk      (clk),
        .we       (we_s),
        .wr_sel   (tgt_s),
        .wr_cnt   (wr_cnt_r),
        .wr_data  (sample_in),
        .rd_sel   (rd_sel_r),
        .rd_frame (rd_frame_s)
    );

    // Writer target selection, bank release and claim decisions.
    always_comb begin
        done_edge_s = fft_done & ~done_q_r;
        release_s   = (state_r == WAIT) && (done_edge_s || (timer_r == TMR_LAST));
        other_sel_s = ~wr_sel_r;
        // A stalled writer jumps to the other bank as soon as it is seen FREE.
        if (bank_writable(bank_st_r[wr_sel_r])) begin
            tgt_s    = wr_sel_r;
            can_wr_s = 1'b1;
        end else if (bank_st_r[other_sel_s] == FREE) begin
            tgt_s    = other_sel_s;
            can_wr_s = 1'b1;
        end else begin
            tgt_s    = wr_sel_r;
            can_wr_s = 1'b0;
        end
        we_s   = sample_valid & can_wr_s;
        last_s = (wr_cnt_r == CNT_LAST);
        // A release landing on the completing edge counts as already free.
        other_free_s = (bank_st_r[~tgt_s] == FREE) || (release_s && (rd_sel_r != tgt_s));
        if ((bank_st_r[0] == READY) && (bank_st_r[1] == READY)) begin
            claim_sel_s = ~wr_sel_r;
        end else if (bank_st_r[1] == READY) begin
            claim_sel_s = 1'b1;
        end else begin
            claim_sel_s = 1'b0;
        end
    end

    // Zero-extended view of the bank under transform.
    always_comb begin
        for (int k = 0; k < N; k++) begin
            fft_samples[k] = {{(WIDTH - SAMPLE_W){1'b0}}, rd_frame_s[k]};
        end
    end

    // Sequencer FSM, bank-state tracking, writer pointer and sticky flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            bank_st_r[0] <= FREE;
            bank_st_r[1] <= FREE;
            rd_sel_r     <= 1'b0;
            wr_sel_r     <= 1'b0;
            wr_cnt_r     <= '0;
            timer_r      <= '0;
            done_q_r     <= 1'b0;
            fft_start    <= 1'b0;
            frame_ready  <= 1'b0;
            busy         <= 1'b0;
            overrun      <= 1'b0;
            fft_timeout  <= 1'b0;
        end else begin
            done_q_r    <= fft_done;
            fft_start   <= 1'b0;
            frame_ready <= 1'b0;
            case (state_r)
                IDLE: begin
                    if ((bank_st_r[0] == READY) || (bank_st_r[1] == READY)) begin
                        rd_sel_r               <= claim_sel_s;
                        bank_st_r[claim_sel_s] <= PROC;
                        fft_start              <= 1'b1;
                        busy                   <= 1'b1;
                        state_r                <= KICK;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                KICK: begin
                    timer_r <= '0;
                    state_r <= WAIT;
                end
                WAIT: begin
                    if (release_s) begin
                        bank_st_r[rd_sel_r] <= FREE;
                        busy                <= 1'b0;
                        state_r             <= IDLE;
                        if (done_edge_s) begin
                            frame_ready <= 1'b1;
                        end else begin
                            fft_timeout <= 1'b1;
                        end
                    end else begin
                        timer_r <= timer_r + TW'(1);
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase

            wr_sel_r <= tgt_s;
            if (we_s) begin
                if (last_s) begin
                    bank_st_r[tgt_s] <= READY;
                    wr_cnt_r         <= '0;
                    if (other_free_s) begin
                        wr_sel_r <= ~tgt_s;
                    end
                end else begin
                    bank_st_r[tgt_s] <= FILLING;
                    wr_cnt_r         <= wr_cnt_r + CW'(1);
                end
            end else if (sample_valid) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Directed bench for fft_frame_sequencer: single frame, ping-pong, overrun/timeout,
// simultaneous free/complete, reset mid-WAIT and gapped input.
module tb_fft_frame_sequencer;

    logic               clk = 1'b0;
    logic               rst;
    logic               sample_valid;
    logic [11:0]        sample_in;
    logic               fft_start;
    logic               fft_done;
    logic [0:255][17:0] fft_samples;
    logic               frame_ready;
    logic               busy;
    logic               overrun;
    logic               fft_timeout;

    int compared   = 0;
    int mismatched = 0;
    int start_seen = 0;
    int ready_seen = 0;

    fft_frame_sequencer #(
        .WIDTH    (18),
        .N        (256),
        .SAMPLE_W (12),
        .TIMEOUT  (4096)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_valid (sample_valid),
        .sample_in    (sample_in),
        .fft_start    (fft_start),
        .fft_done     (fft_done),
        .fft_samples  (fft_samples),
        .frame_ready  (frame_ready),
        .busy         (busy),
        .overrun      (overrun),
        .fft_timeout  (fft_timeout)
    );

    always #5 clk = ~clk;

    // Pulse counters sampled mid-cycle.
    always @(negedge clk) begin
        if (fft_start === 1'b1) start_seen <= start_seen + 1;
        if (frame_ready === 1'b1) ready_seen <= ready_seen + 1;
    end

    function automatic logic [11:0] samp(input int k);
        return 12'((k * 29 + 7) % 4096);
    endfunction

    function automatic int count_bad(input int base);
        int bad = 0;
        for (int k = 0; k < 256; k++) begin
            if (fft_samples[k] !== {6'b000000, samp(base + k)}) bad++;
        end
        return bad;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sample_valid = 1'b0;
        sample_in = 12'd0;
        fft_done = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic send_samples(input int first, input int count, input int gap);
        for (int i = 0; i < count; i++) begin
            sample_valid = 1'b1;
            sample_in = samp(first + i);
            tick();
            sample_valid = 1'b0;
            repeat (gap) tick();
        end
        sample_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        compared++; if (fft_start !== 1'b0) begin mismatched++; $display("FAIL reset_fft_start: got %b want 0", fft_start); end
        compared++; if (frame_ready !== 1'b0) begin mismatched++; $display("FAIL reset_frame_ready: got %b want 0", frame_ready); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b want 0", busy); end
        compared++; if (overrun !== 1'b0) begin mismatched++; $display("FAIL reset_overrun: got %b want 0", overrun); end
        compared++; if (fft_timeout !== 1'b0) begin mismatched++; $display("FAIL reset_timeout: got %b want 0", fft_timeout); end
    endtask

    task automatic test_single_frame();
        int s0;
        int bad;
        do_reset();
        s0 = start_seen;
        send_samples(0, 256, 0);
        compared++; if (fft_start !== 1'b0) begin mismatched++; $display("FAIL t1_start_early: got %b want 0", fft_start); end
        tick();
        compared++; if (fft_start !== 1'b1) begin mismatched++; $display("FAIL t1_start: got %b want 1", fft_start); end
        compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL t1_busy: got %b want 1", busy); end
        bad = count_bad(0);
        compared++; if (bad != 0) begin mismatched++; $display("FAIL t1_data: %0d bad words, word0 got %h want %h", bad, fft_samples[0], {6'b000000, samp(0)}); end
        tick();
        compared++; if (fft_start !== 1'b0) begin mismatched++; $display("FAIL t1_start_width: got %b want 0", fft_start); end
        repeat (298) tick();
        compared++; if (frame_ready !== 1'b0) begin mismatched++; $display("FAIL t1_ready_early: got %b want 0", frame_ready); end
        fft_done = 1'b1;
        tick();
        compared++; if (frame_ready !== 1'b1) begin mismatched++; $display("FAIL t1_ready: got %b want 1", frame_ready); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL t1_busy_end: got %b want 0", busy); end
        fft_done = 1'b0;
        tick();
        compared++; if (frame_ready !== 1'b0) begin mismatched++; $display("FAIL t1_ready_width: got %b want 0", frame_ready); end
        compared++; if (start_seen - s0 != 1) begin mismatched++; $display("FAIL t1_start_count: got %0d want 1", start_seen - s0); end
    endtask

    task automatic test_ping_pong();
        int n;
        int bad;
        int r0;
        do_reset();
        r0 = ready_seen;
        fork
            send_samples(1000, 512, 0);
            begin
                n = 0;
                while (fft_start !== 1'b1 && n < 400) begin tick(); n++; end
                compared++; if (fft_start !== 1'b1) begin mismatched++; $display("FAIL t2_start1: got %b want 1 within 400 cycles", fft_start); end
                bad = count_bad(1000);
                compared++; if (bad != 0) begin mismatched++; $display("FAIL t2_data1: %0d bad words got %h want %h", bad, fft_samples[0], {6'b000000, samp(1000)}); end
                repeat (199) tick();
                fft_done = 1'b1;
                tick();
                compared++; if (frame_ready !== 1'b1) begin mismatched++; $display("FAIL t2_ready1: got %b want 1", frame_ready); end
                fft_done = 1'b0;
            end
        join
        compared++; if (fft_start !== 1'b0) begin mismatched++; $display("FAIL t2_start2_early: got %b want 0", fft_start); end
        tick();
        compared++; if (fft_start !== 1'b1) begin mismatched++; $display("FAIL t2_start2: got %b want 1", fft_start); end
        bad = count_bad(1256);
        compared++; if (bad != 0) begin mismatched++; $display("FAIL t2_data2: %0d bad words got %h want %h", bad, fft_samples[0], {6'b000000, samp(1256)}); end
        compared++; if (overrun !== 1'b0) begin mismatched++; $display("FAIL t2_overrun: got %b want 0", overrun); end
        compared++; if (ready_seen - r0 != 1) begin mismatched++; $display("FAIL t2_ready_count: got %0d want 1", ready_seen - r0); end
    endtask

    task automatic test_overrun_timeout();
        int bad;
        int r0;
        do_reset();
        r0 = ready_seen;
        send_samples(2000, 512, 0);
        compared++; if (overrun !== 1'b0) begin mismatched++; $display("FAIL t3_overrun_early: got %b want 0", overrun); end
        send_samples(2512, 256, 0);
        compared++; if (overrun !== 1'b1) begin mismatched++; $display("FAIL t3_overrun: got %b want 1", overrun); end
        repeat (3585) tick();
        compared++; if (fft_timeout !== 1'b0 || busy !== 1'b1) begin mismatched++; $display("FAIL t3_timeout_early: got timeout=%b busy=%b want 0/1", fft_timeout, busy); end
        tick();
        compared++; if (fft_timeout !== 1'b1) begin mismatched++; $display("FAIL t3_timeout: got %b want 1", fft_timeout); end
        compared++; if (busy !== 1'b0 || frame_ready !== 1'b0) begin mismatched++; $display("FAIL t3_abandon: got busy=%b ready=%b want 0/0", busy, frame_ready); end
        tick();
        compared++; if (fft_start !== 1'b1) begin mismatched++; $display("FAIL t3_start2: got %b want 1", fft_start); end
        bad = count_bad(2256);
        compared++; if (bad != 0) begin mismatched++; $display("FAIL t3_data2: %0d bad words got %h want %h", bad, fft_samples[0], {6'b000000, samp(2256)}); end
        compared++; if (ready_seen != r0) begin mismatched++; $display("FAIL t3_no_ready: got %0d want %0d", ready_seen, r0); end
    endtask

    task automatic test_simultaneous();
        int n;
        int bad;
        do_reset();
        fork
            send_samples(3000, 512, 0);
            begin
                n = 0;
                while (fft_start !== 1'b1 && n < 400) begin tick(); n++; end
                compared++; if (fft_start !== 1'b1) begin mismatched++; $display("FAIL t4_start1: got %b want 1 within 400 cycles", fft_start); end
                repeat (254) tick();
                fft_done = 1'b1;
                tick();
                compared++; if (frame_ready !== 1'b1) begin mismatched++; $display("FAIL t4_ready1: got %b want 1", frame_ready); end
            end
        join
        fft_done = 1'b0;
        send_samples(3512, 256, 0);
        compared++; if (overrun !== 1'b0) begin mismatched++; $display("FAIL t4_overrun: got %b want 0", overrun); end
        fft_done = 1'b1;
        tick();
        compared++; if (frame_ready !== 1'b1) begin mismatched++; $display("FAIL t4_ready2: got %b want 1", frame_ready); end
        tick();
        compared++; if (fft_start !== 1'b1) begin mismatched++; $display("FAIL t4_start3: got %b want 1", fft_start); end
        bad = count_bad(3512);
        compared++; if (bad != 0) begin mismatched++; $display("FAIL t4_data3: %0d bad words got %h want %h", bad, fft_samples[0], {6'b000000, samp(3512)}); end
        fft_done = 1'b0;
    endtask

    task automatic test_reset_mid_wait();
        int s0;
        int r0;
        int bad;
        do_reset();
        s0 = start_seen;
        send_samples(4000, 256, 0);
        repeat (52) tick();
        compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL t5_busy_wait: got %b want 1", busy); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        compared++; if ({fft_start, frame_ready, busy, overrun, fft_timeout} !== 5'b00000) begin mismatched++; $display("FAIL t5_outputs: got %b want 00000", {fft_start, frame_ready, busy, overrun, fft_timeout}); end
        r0 = ready_seen;
        tick();
        fft_done = 1'b1;
        tick();
        tick();
        fft_done = 1'b0;
        tick();
        compared++; if (ready_seen != r0) begin mismatched++; $display("FAIL t5_no_ready: got %0d want %0d", ready_seen, r0); end
        send_samples(4500, 255, 0);
        repeat (5) tick();
        compared++; if (start_seen - s0 != 1) begin mismatched++; $display("FAIL t5_no_start: got %0d want 1", start_seen - s0); end
        sample_valid = 1'b1;
        sample_in = samp(4755);
        tick();
        sample_valid = 1'b0;
        tick();
        compared++; if (fft_start !== 1'b1) begin mismatched++; $display("FAIL t5_start: got %b want 1", fft_start); end
        bad = count_bad(4500);
        compared++; if (bad != 0) begin mismatched++; $display("FAIL t5_data: %0d bad words got %h want %h", bad, fft_samples[0], {6'b000000, samp(4500)}); end
    endtask

    task automatic test_gapped();
        int bad;
        do_reset();
        send_samples(0, 255, 2);
        sample_valid = 1'b1;
        sample_in = samp(255);
        tick();
        sample_valid = 1'b0;
        compared++; if (fft_start !== 1'b0) begin mismatched++; $display("FAIL t6_start_early: got %b want 0", fft_start); end
        tick();
        compared++; if (fft_start !== 1'b1) begin mismatched++; $display("FAIL t6_start: got %b want 1", fft_start); end
        bad = count_bad(0);
        compared++; if (bad != 0) begin mismatched++; $display("FAIL t6_data: %0d bad words got %h want %h", bad, fft_samples[0], {6'b000000, samp(0)}); end
        tick();
        compared++; if (fft_start !== 1'b0) begin mismatched++; $display("FAIL t6_start_width: got %b want 0", fft_start); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        sample_valid = 1'b0;
        sample_in = 12'd0;
        fft_done = 1'b0;
        test_reset();
        test_single_frame();
        test_ping_pong();
        test_overrun_timeout();
        test_simultaneous();
        test_reset_mid_wait();
        test_gapped();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
